// File: rtl/output_bcd_converter_if.sv
// Handshake and result bus between the result register, the BCD converter and
// the seven-segment driver.
interface output_bcd_converter_if #(
   parameter int N      = 16,
   parameter int DIGITS = 4
);
   logic                  load;
   logic [N-1:0]          data;
   logic                  busy;
   logic                  done;
   logic [4*DIGITS-1:0]   bcd;
   logic                  neg;
   logic                  overflow;
   logic [DIGITS-1:0]     blank;

   modport master (output load, data,
                   input  busy, done, bcd, neg, overflow, blank);
   modport slave  (input  load, data,
                   output busy, done, bcd, neg, overflow, blank);
endinterface

// File: rtl/output_bcd_converter.sv
// Sequential binary-to-BCD converter: one divide-by-10 per clock, with the
// visible result (digits, sign, overflow, blanking) swapped in atomically on done.
module output_bcd_converter #(
   parameter int N      = 16,
   parameter int DIGITS = 4,
   parameter bit SIGNED = 1'b0
) (
   input  logic                   Clock,
   input  logic                   Reset,
   output_bcd_converter_if.slave  bus
);
   localparam int                CW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [CW-1:0]     LAST      = CW'(DIGITS - 1);
   localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);
   localparam logic [N-1:0]      TEN       = N'(10);

   typedef enum logic {IDLE, CONV} state_t;

   state_t                   state, state_nxt;
   logic [N-1:0]             num, mag;
   logic [CW-1:0]            step;
   logic [DIGITS-1:0][3:0]   shadow, shadow_nxt, bcd_q;
   logic [DIGITS-1:0]        blank_q, blank_nxt;
   logic                     pend_neg, neg_in, neg_q, ovf_q, ovf_nxt, done_q;
   logic                     last_step, zero_run;

   // State register
   always_ff @(posedge Clock) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next state: a load always (re)starts, even in the final-step cycle
   always_comb begin
      state_nxt = state;
      if (bus.load)      state_nxt = CONV;
      else if (last_step) state_nxt = IDLE;
   end

   // Outputs
   always_comb begin
      last_step    = (state == CONV) && (step == LAST);
      bus.busy     = (state == CONV);
      bus.done     = done_q;
      bus.bcd      = bcd_q;
      bus.neg      = neg_q;
      bus.overflow = ovf_q;
      bus.blank    = blank_q;
   end

   // Magnitude of -data stays exact for the most negative value as an N-bit unsigned
   always_comb begin
      neg_in             = SIGNED && bus.data[N-1];
      mag                = neg_in ? -bus.data : bus.data;
      shadow_nxt         = shadow;
      shadow_nxt[step]   = 4'(num % TEN);
      ovf_nxt            = (num / TEN) != '0;
      blank_nxt          = '0;
      zero_run           = 1'b1;
      for (int i = DIGITS - 1; i >= 1; i--) begin
         zero_run     = zero_run && (shadow_nxt[i] == 4'd0);
         blank_nxt[i] = zero_run && !ovf_nxt;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         num      <= '0;
         step     <= '0;
         shadow   <= '0;
         pend_neg <= 1'b0;
         bcd_q    <= '0;
         neg_q    <= 1'b0;
         ovf_q    <= 1'b0;
         blank_q  <= BLANK_RST;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.load) begin
            num      <= mag;
            pend_neg <= neg_in;
            step     <= '0;
         end else if (state == CONV) begin
            shadow <= shadow_nxt;
            num    <= num / TEN;
            step   <= step + 1'b1;
            if (last_step) begin
               bcd_q   <= shadow_nxt;
               neg_q   <= pend_neg;
               ovf_q   <= ovf_nxt;
               blank_q <= blank_nxt;
               done_q  <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_output_bcd_converter.sv
// Bench for output_bcd_converter: three configurations checked against an
// arithmetic reference model with directed and random values.
module tb_output_bcd_converter;
   logic Clock = 1'b0;
   logic Reset;
   always #5 Clock = ~Clock;

   output_bcd_converter_if #(.N(16), .DIGITS(4)) if0 ();
   output_bcd_converter_if #(.N(16), .DIGITS(4)) if1 ();
   output_bcd_converter_if #(.N(16), .DIGITS(5)) if2 ();

   output_bcd_converter #(.N(16), .DIGITS(4), .SIGNED(1'b0)) u0 (.Clock(Clock), .Reset(Reset), .bus(if0.slave));
   output_bcd_converter #(.N(16), .DIGITS(4), .SIGNED(1'b1)) u1 (.Clock(Clock), .Reset(Reset), .bus(if1.slave));
   output_bcd_converter #(.N(16), .DIGITS(5), .SIGNED(1'b1)) u2 (.Clock(Clock), .Reset(Reset), .bus(if2.slave));

   int errors = 0;
   int checks = 0;
   logic        o_busy, o_done, o_neg, o_ovf;
   logic [19:0] o_bcd;
   logic [4:0]  o_blank;
   logic [19:0] prev_bcd [3];

   function automatic int ndig(input int inst);
      return (inst == 2) ? 5 : 4;
   endfunction

   // Reference: decimal digits of the magnitude straight from integer arithmetic
   function automatic void model(input logic [15:0] d, input int nd, input bit sgn,
                                 output logic [19:0] e_bcd, output logic e_neg,
                                 output logic e_ovf, output logic [4:0] e_blank);
      longint mag, lim, low, pw;
      e_neg = sgn && d[15];
      mag   = e_neg ? (64'd65536 - longint'(d)) : longint'(d);
      lim   = 1;
      for (int i = 0; i < nd; i++) lim = lim * 10;
      e_ovf   = (mag >= lim);
      low     = mag % lim;
      e_bcd   = '0;
      e_blank = '0;
      pw      = 1;
      for (int i = 0; i < nd; i++) begin
         e_bcd[4*i +: 4] = 4'((low / pw) % 10);
         if (i > 0 && !e_ovf && low < pw) e_blank[i] = 1'b1;
         pw = pw * 10;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int inst, input logic ld, input logic [15:0] d);
      case (inst)
         0:       begin if0.load = ld; if0.data = d; end
         1:       begin if1.load = ld; if1.data = d; end
         default: begin if2.load = ld; if2.data = d; end
      endcase
   endtask

   task automatic sample(input int inst);
      case (inst)
         0: begin
            o_busy = if0.busy; o_done = if0.done; o_neg = if0.neg; o_ovf = if0.overflow;
            o_bcd = 20'(if0.bcd); o_blank = 5'(if0.blank);
         end
         1: begin
            o_busy = if1.busy; o_done = if1.done; o_neg = if1.neg; o_ovf = if1.overflow;
            o_bcd = 20'(if1.bcd); o_blank = 5'(if1.blank);
         end
         default: begin
            o_busy = if2.busy; o_done = if2.done; o_neg = if2.neg; o_ovf = if2.overflow;
            o_bcd = 20'(if2.bcd); o_blank = 5'(if2.blank);
         end
      endcase
   endtask

   task automatic convert(input int inst, input logic [15:0] d, input string tag);
      logic [19:0] eb;
      logic        en, eo;
      logic [4:0]  ebl;
      int          lat, busy_cnt;
      model(d, ndig(inst), inst != 0, eb, en, eo, ebl);
      @(negedge Clock); drive(inst, 1'b1, d);
      @(negedge Clock); drive(inst, 1'b0, d);
      lat = 0; busy_cnt = 0;
      sample(inst);
      while (!o_done && lat < 12) begin
         if (o_busy) busy_cnt++;
         if (lat == 1) chk({tag, ".hold"}, 32'(o_bcd), 32'(prev_bcd[inst]));
         @(negedge Clock); lat++; sample(inst);
      end
      chk({tag, ".latency"}, lat, ndig(inst));
      chk({tag, ".busycyc"}, busy_cnt, ndig(inst));
      chk({tag, ".busy_at_done"}, 32'(o_busy), 32'(0));
      chk({tag, ".bcd"}, 32'(o_bcd), 32'(eb));
      chk({tag, ".neg"}, 32'(o_neg), 32'(en));
      chk({tag, ".ovf"}, 32'(o_ovf), 32'(eo));
      chk({tag, ".blank"}, 32'(o_blank), 32'(ebl));
      @(negedge Clock); sample(inst);
      chk({tag, ".done_pulse"}, 32'(o_done), 32'(0));
      prev_bcd[inst] = eb;
   endtask

   // Second load sampled 'gap' edges after the first; only the second may complete
   task automatic restart(input int gap, input logic [15:0] d1, input logic [15:0] d2, input string tag);
      logic [19:0] eb;
      logic        en, eo;
      logic [4:0]  ebl;
      int          ndone, at;
      model(d2, 4, 1'b0, eb, en, eo, ebl);
      ndone = 0; at = -1;
      @(negedge Clock); drive(0, 1'b1, d1);
      @(negedge Clock); drive(0, 1'b0, d1);
      repeat (gap - 1) @(negedge Clock);
      drive(0, 1'b1, d2);
      @(negedge Clock); drive(0, 1'b0, d2);
      for (int c = 1; c <= 8; c++) begin
         @(negedge Clock); sample(0);
         if (o_done) begin ndone++; at = c; end
      end
      chk({tag, ".ndone"}, ndone, 1);
      chk({tag, ".done_at"}, at, 4);
      chk({tag, ".bcd"}, 32'(o_bcd), 32'(eb));
      prev_bcd[0] = eb;
   endtask

   initial begin
      int ndone;
      Reset = 1'b1;
      for (int i = 0; i < 3; i++) begin drive(i, 1'b0, 16'd0); prev_bcd[i] = '0; end
      repeat (2) @(negedge Clock);
      sample(0);
      chk("rst.busy", 32'(o_busy), 0);
      chk("rst.done", 32'(o_done), 0);
      chk("rst.bcd", 32'(o_bcd), 0);
      chk("rst.blank", 32'(o_blank), 32'b1110);
      chk("rst.ovf", 32'(o_ovf), 0);
      sample(2);
      chk("rst.blank5", 32'(o_blank), 32'b11110);
      Reset = 1'b0;

      convert(0, 16'd1234, "u1234");
      convert(0, 16'd7, "u7");
      convert(0, 16'd0, "u0");
      convert(0, 16'd65535, "u65535");
      convert(0, 16'd9999, "u9999");
      convert(0, 16'd10000, "u10000");
      convert(1, 16'hFF85, "s-123");
      convert(1, 16'h8000, "s4min");
      convert(1, 16'hFFFF, "s-1");
      convert(2, 16'h8000, "s5min");
      convert(2, 16'h7FFF, "s5max");

      restart(2, 16'd1234, 16'd42, "rs_gap2");
      restart(4, 16'd1234, 16'd42, "rs_final");

      // Reset in the middle of a conversion
      @(negedge Clock); drive(0, 1'b1, 16'd9999);
      @(negedge Clock); drive(0, 1'b0, 16'd9999);
      @(negedge Clock); Reset = 1'b1;
      @(negedge Clock); Reset = 1'b0; sample(0);
      chk("midrst.busy", 32'(o_busy), 0);
      chk("midrst.done", 32'(o_done), 0);
      chk("midrst.bcd", 32'(o_bcd), 0);
      chk("midrst.blank", 32'(o_blank), 32'b1110);
      ndone = 0;
      for (int c = 0; c < 6; c++) begin @(negedge Clock); sample(0); if (o_done) ndone++; end
      chk("midrst.nodone", ndone, 0);
      for (int i = 0; i < 3; i++) prev_bcd[i] = '0;

      // Reset and load together
      drive(0, 1'b1, 16'd1234); Reset = 1'b1;
      @(negedge Clock); drive(0, 1'b0, 16'd1234); Reset = 1'b0; sample(0);
      chk("rstload.busy", 32'(o_busy), 0);
      ndone = 0;
      for (int c = 0; c < 6; c++) begin @(negedge Clock); sample(0); if (o_done) ndone++; end
      chk("rstload.nodone", ndone, 0);
      chk("rstload.bcd", 32'(o_bcd), 0);

      for (int k = 0; k < 15; k++)
         for (int inst = 0; inst < 3; inst++)
            convert(inst, 16'($urandom), $sformatf("rnd%0d_%0d", inst, k));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/output_bcd_converter.md
Name: output_bcd_converter

Overview:
Parametrised binary-to-BCD converter for the display output path. It converts an N-bit binary value, unsigned or two's-complement, into DIGITS BCD digits using one divide-by-10 step per clock. It adds a busy/done handshake, atomic output update, overflow detection, sign extraction and a leading-zero blanking mask. It sits between the calculator result register and the seven-segment driver.

Parameters:
N, 16, input data width in bits (≥4)
DIGITS, 4, number of BCD digits produced (≥1)
SIGNED, 0, 1 = data is two's-complement; 0 = data is unsigned

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous reset, active-high
load  input  1  start conversion of data; sampled every cycle
data  input  N  binary value to convert
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when the outputs have been updated
bcd  output  4*DIGITS  digit i in bits [4i+3:4i]; digit 0 = least significant
neg  output  1  result is negative (SIGNED=1 only; tied 0 otherwise)
overflow  output  1  magnitude ≥ 10^DIGITS
blank  output  DIGITS  bit i = 1 when digit i is a leading zero; bit 0 always 0

Behaviour:
- Clock is the single clock; Reset is synchronous and active-high. All state changes on the rising edge of Clock.
- Reset (dominates load): state=IDLE, busy=0, done=0, bcd=0, neg=0, overflow=0, blank={DIGITS-1 ones, 0}, so the display shows "0". Reset mid-conversion aborts it with no done pulse.
- States: IDLE, CONV. A step counter runs 0..DIGITS-1.
- IDLE, load=1: latch the magnitude into the working register. If SIGNED=1 and data[N-1]=1, the magnitude is the N-bit unsigned value of -data; the most negative value maps to 2^(N-1) without loss. Latch the sign into a pending-neg flag. Clear the step counter. Go to CONV with busy=1.
- CONV, each cycle: write num%10 into shadow digit[step], set num=num/10, increment step.
- Final step (step=DIGITS-1):
  - Compute pending overflow as (num/10 != 0).
  - On the same edge, copy the shadow digits to bcd and pending-neg to neg, update overflow and blank, set done=1 and busy=0, and return to IDLE.
- Latency: load sampled at edge 0 → done high and outputs valid after edge DIGITS. Next load is accepted in the cycle done is high.
- Outputs bcd/neg/overflow/blank change only on the done edge. They hold the previous result during a conversion.
- Load while busy (including in the final-step cycle): restart with the new data. The in-flight result is discarded: no done pulse and no output update.
- Overflow: bcd holds the low DIGITS decimal digits of the magnitude (value mod 10^DIGITS), overflow=1, blank all 0.
- Blanking (overflow=0): for i≥1, blank[i]=1 iff digit i and all higher digits are 0. blank[0]=0 always.
- Arithmetic: divide and modulo are on N-bit unsigned values. The remainder is truncated to 4 bits. All widths derive from N and DIGITS. There are no hard-coded widths.
- done is low in every cycle except the completion cycle. busy and done are never high together.

Test Plan:
- N=16, DIGITS=4, SIGNED=0, load data=1234 → busy high 4 cycles, done pulse after edge 4, bcd=16'h1234, blank=4'b0000, overflow=0, neg=0.
- Same config, data=7 → bcd=16'h0007, blank=4'b1110. Then data=0 → bcd=0, blank=4'b1110. Check that outputs hold 0007 until the second done.
- Same config, data=65535 → overflow=1, bcd=16'h5535, blank=4'b0000.
- SIGNED=1, data=16'hFF85 (-123) → neg=1, bcd=16'h0123, blank=4'b1000. With DIGITS=5, data=16'h8000 → neg=1, bcd=20'h32768, overflow=0.
- Load 1234, then load 42 two cycles later → exactly one done, 4 cycles after the second load, bcd=16'h0042. Repeat with the second load in the final-step cycle: same result, no done for 1234.
- Reset asserted mid-conversion → next cycle busy=0, done=0, bcd=0, blank=4'b1110. No done follows. Reset and load asserted together → reset wins.
